// File: rtl/sprite_read_arbiter.sv
// rtl/sprite_read_arbiter.sv - round-robin arbiter sharing the sprite_storage r0 read port
// Optional hit/stall counters are built when SPRITE_ARB_STATS_EN is defined.
module sprite_read_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int RD_LAT           = 1,
    parameter int SPRITE_NUM       = 8,
    parameter int SPRITE_ADDR_SIZE = 7,
    parameter int SEL_W            = $clog2(SPRITE_NUM),
    parameter int ADDR_W           = SPRITE_ADDR_SIZE + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*SEL_W-1:0]  req_select,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [3:0]                rdata,
    input  logic                      w_busy,
    output logic                      r_en,
    output logic [SEL_W-1:0]          r_select,
    output logic [ADDR_W-1:0]         r_addr,
    input  logic [3:0]                r_data
`ifdef SPRITE_ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               grant_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             grant_ok;

    logic [RD_LAT:0]  tag_v;
    logic [IDX_W-1:0] tag_idx [RD_LAT+1];

    // Search upward from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[(int'(ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // The writer always owns port A; gnt is also masked while reset is held.
    assign grant_ok = win_found && !w_busy && reset;
    assign gnt      = grant_ok ? (ONE_HOT0 << win_idx) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            r_en     <= 1'b0;
            r_select <= '0;
            r_addr   <= '0;
        end else begin
            r_en <= grant_ok;
            if (grant_ok) begin
                ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                r_select <= req_select[win_idx*SEL_W +: SEL_W];
                r_addr   <= req_addr[win_idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // Stage k holds the read issued k+1 cycles ago; the last stage lines up with r_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            tag_v[0]   <= grant_ok;
            tag_idx[0] <= win_idx;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    assign rvalid = tag_v[RD_LAT] ? (ONE_HOT0 << tag_idx[RD_LAT]) : '0;
    assign rdata  = r_data;

`ifdef SPRITE_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else if (stats_clr) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if ((|req) && w_busy && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (grant_ok && (grant_cnt != 16'hFFFF)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sprite_read_arbiter.md
Name: sprite_read_arbiter

Overview:
- Shares the single read path of sprite_storage port r0 among NUM_REQ pixel requesters (scanline renderers, collision probe, debug readback).
- Round-robin arbitration, one read issued per cycle.
- Stalls while the SPI write path owns port A.
- Tracks in-flight reads through the fixed BRAM latency and routes each returned 4-bit pixel to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RD_LAT, 1, sprite_bram read latency in cycles, from address presented at r_addr to data valid on r_data (1..3).
- SEL_W, $clog2(SPRITE_NUM), sprite select width.
- ADDR_W, SPRITE_ADDR_SIZE+1, nibble address width within one sprite.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; held until granted.
- req_select  in  NUM_REQ*SEL_W  packed sprite select; slice i belongs to requester i.
- req_addr  in  NUM_REQ*ADDR_W  packed nibble address; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot combinational grant.
- rvalid  out  NUM_REQ  one-hot pulse; rdata is valid for that requester.
- rdata  out  4  returned pixel, shared by all requesters.
- w_busy  in  1  write controller w_en; port A is owned by the writer this cycle.
- r_en  out  1  a read is issued this cycle.
- r_select  out  SEL_W  to sprite_storage r0_select.
- r_addr  out  ADDR_W  to sprite_storage r0_addr.
- r_data  in  4  from sprite_storage r0_data.

Behaviour:
- Reset values:
  - r_en=0, r_select=0, r_addr=0.
  - rvalid=0; tag pipeline cleared.
  - RR pointer=0.
  - gnt forced to 0 while reset is low.
- Arbitration (combinational, cycle t):
  - If w_busy=1 or req=0, then gnt=0.
  - Otherwise gnt = first set bit of req, searching from ptr upward and wrapping modulo NUM_REQ.
- Pointer update: on an edge where gnt!=0, ptr <= winner+1 mod NUM_REQ. Otherwise ptr holds.
- Requester protocol:
  - The requester sees gnt[i]=1 in cycle t and considers the request consumed at that edge.
  - It may present a new address or drop req in t+1.
  - req held high after a grant is treated as a new request.
- Issue (edge end of t):
  - r_en <= |gnt.
  - r_select/r_addr <= winner's slices.
  - If no grant: r_en <= 0 and r_select/r_addr hold their previous values.
- Tag pipeline:
  - A shift register of RD_LAT+1 stages carries (valid, winner index).
  - Stage 0 is loaded at the issue edge.
  - Data for a read issued at edge t appears on r_data in cycle t+1+RD_LAT.
- Return path:
  - In cycle t+1+RD_LAT: rvalid[idx]=1 for exactly one cycle; rdata=r_data, passed combinationally.
  - rdata is don't-care when rvalid=0.
- Throughput: one grant per cycle, sustained. Returns arrive in issue order with no gaps beyond the gaps at issue.
- w_busy:
  - Sampled combinationally; blocks the grant in the same cycle.
  - In-flight reads still complete and return.
  - A write only conflicts on port A, so returns are unaffected.
- Simultaneous req and w_busy: the writer always wins. No starvation guarantee while w_busy stays high.
- Reset mid-operation: all in-flight tags are dropped; no rvalid pulse is produced after reset deasserts.
- Out-of-range req_select (>=SPRITE_NUM) passes through unchecked; the address wraps in storage.

Optional Feature:
- Macro: SPRITE_ARB_STATS_EN.
- When defined, add outputs:
  - stall_cnt (16 bits): counts cycles with req!=0 and w_busy=1.
  - grant_cnt (16 bits): counts cycles with gnt!=0.
- Both counters saturate at 0xFFFF, reset to 0, and clear synchronously when input stats_clr=1. stats_clr takes priority over increment in the same cycle.
- When undefined: stall_cnt, grant_cnt and stats_clr are absent and no counter logic exists.

Test Plan:
- Single request, RD_LAT=1: req[0]=1, sel=3, addr=10 in cycle 0 → gnt=0001 in cycle 0; r_en=1, r_select=3, r_addr=10 in cycle 1; rvalid=0001 in cycle 2 with rdata = model nibble(3,10).
- All four requests held continuously for 8 cycles from ptr=0 → gnt sequence 0001, 0010, 0100, 1000, 0001, ...; rvalid follows 2 cycles later in the same order, each with the correct nibble.
- req[1] held while w_busy=1 for cycles 0-4 → gnt=0 in cycles 0-4; gnt=0010 in cycle 5. With SPRITE_ARB_STATS_EN defined: stall_cnt=5, grant_cnt=1.
- Back-to-back alternating req[2]/req[3] with distinct addresses, RD_LAT=2 build → rvalid lands at issue+3, routed to the correct index, rdata matches the per-address model every cycle.
- reset driven low one cycle after a grant (read in flight), released 3 cycles later → no rvalid pulse at any time; after release r_en=0 and ptr=0, and the first request is granted normally.
- Saturation (stats build): force grant_cnt to 0xFFFE, issue 3 grants → grant_cnt=0xFFFF; stats_clr=1 together with a grant → grant_cnt=0.
